// File: rtl/cordic_host_pkg.sv
// Shared types and codes for the CORDIC sin/cos host requester.
package cordic_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    ACK,
    RELEASE,
    OUT
  } state_e;

  localparam logic [1:0] MODE_COS  = 2'b00;
  localparam logic [1:0] MODE_SIN  = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;

  localparam logic OP_SIN = 1'b1;
  localparam logic OP_COS = 1'b0;

  // Code 11 behaves exactly like "both".
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_BOTH : m;
  endfunction

endpackage

// File: rtl/cordic_host_watchdog.sv
// WAIT-state watchdog: counts enabled cycles, flags the cycle the limit is reached.
module cordic_host_watchdog #(
  parameter int unsigned TO_W  = 10,
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired_c
);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + TO_W'(1);
    end
  end

  // Count is 0 on the first WAIT cycle, so LIMIT-1 marks the LIMIT-th cycle.
  assign expired_c = en && (count == TO_W'(LIMIT - 1));

endmodule

// File: rtl/cordic_sincos_host.sv
// Host requester for the sin/cos CORDIC datapath: command port -> start/ack handshake -> response port.
// Defining CORDIC_HOST_TIMEOUT_EN adds a watchdog that aborts a stalled WAIT.
module cordic_sincos_host
  import cordic_host_pkg::*;
#(
  parameter int unsigned W              = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned TO_W           = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_angle,
  input  logic [1:0]   cmd_region,
  input  logic [1:0]   cmd_mode,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_op,
  output logic         rsp_ovf,
  output logic         rsp_unf,
  output logic         rsp_last,
  output logic         rsp_timeout,
  output logic         beg_fsm_cordic,
  output logic         ack_cordic,
  output logic         operation,
  output logic [W-1:0] data_in,
  output logic [1:0]   shift_region_flag,
  input  logic         ready_cordic,
  input  logic [W-1:0] data_output,
  input  logic         overflow_flag,
  input  logic         underflow_flag
);

  if (64'(TIMEOUT_CYCLES) >= (64'd1 << TO_W)) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be below 2**TO_W");
  end

  state_e       state, state_d;
  logic [1:0]   mode_q, mode_d;
  logic         pass_q, pass_d;
  logic [W-1:0] data_in_d, rsp_data_d;
  logic [1:0]   region_d;
  logic         operation_d, rsp_op_d, rsp_ovf_d, rsp_unf_d, rsp_last_d, rsp_timeout_d;
  logic         wd_expired_c;

`ifdef CORDIC_HOST_TIMEOUT_EN
  cordic_host_watchdog #(
    .TO_W (TO_W),
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state != WAIT),
    .en       (state == WAIT),
    .expired_c(wd_expired_c)
  );
`else
  assign wd_expired_c = 1'b0;
`endif

  // Next state and next values of all registered outputs.
  always_comb begin
    state_d       = state;
    mode_d        = mode_q;
    pass_d        = pass_q;
    data_in_d     = data_in;
    region_d      = shift_region_flag;
    operation_d   = operation;
    rsp_data_d    = rsp_data;
    rsp_op_d      = rsp_op;
    rsp_ovf_d     = rsp_ovf;
    rsp_unf_d     = rsp_unf;
    rsp_last_d    = rsp_last;
    rsp_timeout_d = rsp_timeout;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          data_in_d   = cmd_angle;
          region_d    = cmd_region;
          mode_d      = norm_mode(cmd_mode);
          pass_d      = 1'b0;
          operation_d = (norm_mode(cmd_mode) == MODE_SIN) ? OP_SIN : OP_COS;
          state_d     = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (ready_cordic) begin
          rsp_data_d    = data_output;
          rsp_ovf_d     = overflow_flag;
          rsp_unf_d     = underflow_flag;
          rsp_op_d      = operation;
          rsp_timeout_d = 1'b0;
          rsp_last_d    = !((mode_q == MODE_BOTH) && !pass_q);
          state_d       = ACK;
        end else if (wd_expired_c) begin
          rsp_data_d    = '0;
          rsp_ovf_d     = 1'b0;
          rsp_unf_d     = 1'b0;
          rsp_op_d      = operation;
          rsp_timeout_d = 1'b1;
          rsp_last_d    = 1'b1;
          state_d       = ACK;
        end
      end
      // An aborted transaction never saw ready high, so there is nothing to release.
      ACK: state_d = rsp_timeout ? OUT : RELEASE;
      RELEASE: begin
        if (!ready_cordic) state_d = OUT;
      end
      OUT: begin
        if (rsp_ready) begin
          if (rsp_last) begin
            state_d = IDLE;
          end else begin
            pass_d      = 1'b1;
            operation_d = OP_SIN;
            state_d     = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      mode_q            <= MODE_COS;
      pass_q            <= 1'b0;
      cmd_ready         <= 1'b1;
      beg_fsm_cordic    <= 1'b0;
      ack_cordic        <= 1'b0;
      rsp_valid         <= 1'b0;
      data_in           <= '0;
      shift_region_flag <= '0;
      operation         <= OP_COS;
      rsp_data          <= '0;
      rsp_op            <= OP_COS;
      rsp_ovf           <= 1'b0;
      rsp_unf           <= 1'b0;
      rsp_last          <= 1'b0;
      rsp_timeout       <= 1'b0;
    end else begin
      state             <= state_d;
      mode_q            <= mode_d;
      pass_q            <= pass_d;
      cmd_ready         <= (state_d == IDLE);
      beg_fsm_cordic    <= (state_d == START);
      ack_cordic        <= (state_d == ACK);
      rsp_valid         <= (state_d == OUT);
      data_in           <= data_in_d;
      shift_region_flag <= region_d;
      operation         <= operation_d;
      rsp_data          <= rsp_data_d;
      rsp_op            <= rsp_op_d;
      rsp_ovf           <= rsp_ovf_d;
      rsp_unf           <= rsp_unf_d;
      rsp_last          <= rsp_last_d;
      rsp_timeout       <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_cordic_sincos_host.sv
// Bench for cordic_sincos_host: a timed datapath model plus a per-command response reference.
module tb_cordic_sincos_host;

  localparam int unsigned W = 32;
`ifdef CORDIC_HOST_TIMEOUT_EN
  localparam int unsigned TMO     = 15;
  localparam int          LAT_MAX = 10;
`else
  localparam int unsigned TMO     = 1023;
  localparam int          LAT_MAX = 20;
`endif
  localparam int BUDGET = 200;

  logic         clk, rst;
  logic         cmd_valid, cmd_ready;
  logic [W-1:0] cmd_angle;
  logic [1:0]   cmd_region, cmd_mode;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_op, rsp_ovf, rsp_unf, rsp_last, rsp_timeout;
  logic         beg_fsm_cordic, ack_cordic, operation;
  logic [W-1:0] data_in;
  logic [1:0]   shift_region_flag;
  logic         ready_cordic;
  logic [W-1:0] data_output;
  logic         overflow_flag, underflow_flag;

  cordic_sincos_host #(
    .W             (W),
    .TIMEOUT_CYCLES(TMO),
    .TO_W          (10)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_angle        (cmd_angle),
    .cmd_region       (cmd_region),
    .cmd_mode         (cmd_mode),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_op           (rsp_op),
    .rsp_ovf          (rsp_ovf),
    .rsp_unf          (rsp_unf),
    .rsp_last         (rsp_last),
    .rsp_timeout      (rsp_timeout),
    .beg_fsm_cordic   (beg_fsm_cordic),
    .ack_cordic       (ack_cordic),
    .operation        (operation),
    .data_in          (data_in),
    .shift_region_flag(shift_region_flag),
    .ready_cordic     (ready_cordic),
    .data_output      (data_output),
    .overflow_flag    (overflow_flag),
    .underflow_flag   (underflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_beg = 0;
  int n_ack = 0;

  always @(negedge clk) begin
    if (beg_fsm_cordic) n_beg++;
    if (ack_cordic) n_ack++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_cmd_ready"}, 64'(cmd_ready), 1);
    chk({pfx, "_beg"}, 64'(beg_fsm_cordic), 0);
    chk({pfx, "_ack"}, 64'(ack_cordic), 0);
    chk({pfx, "_operation"}, 64'(operation), 0);
    chk({pfx, "_data_in"}, 64'(data_in), 0);
    chk({pfx, "_region"}, 64'(shift_region_flag), 0);
    chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({pfx, "_rsp_data"}, 64'(rsp_data), 0);
    chk({pfx, "_rsp_flags"}, 64'({rsp_op, rsp_ovf, rsp_unf, rsp_last, rsp_timeout}), 0);
  endtask

  // One command end to end; the datapath answers pass p with data dN / flags fN ({ovf,unf}).
  task automatic run_cmd(input logic [W-1:0] angle, input logic [1:0] region, input logic [1:0] mode,
                         input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [1:0] f0, input logic [1:0] f1,
                         input int lat, input int hold, input int stall);
    int           npass, n, beg0, ack0;
    logic [W-1:0] d;
    logic [1:0]   f;
    logic         exp_op, exp_last;
    npass = mode[1] ? 2 : 1;
    n = 0;
    while (!cmd_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_idle", 64'(cmd_ready), 1);
    beg0 = n_beg;
    ack0 = n_ack;
    cmd_valid  = 1'b1;
    cmd_angle  = angle;
    cmd_region = region;
    cmd_mode   = mode;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_angle = $urandom;
    cmd_mode  = 2'($urandom);
    chk("beg_lat", 64'(beg_fsm_cordic), 1);
    chk("cmd_ready_busy", 64'(cmd_ready), 0);
    for (int p = 0; p < npass; p++) begin
      d = (p == 0) ? d0 : d1;
      f = (p == 0) ? f0 : f1;
      exp_op   = (mode == 2'b01) || (mode[1] && (p == 1));
      exp_last = (p == npass - 1);
      chk("operation", 64'(operation), 64'(exp_op));
      chk("data_in", 64'(data_in), 64'(angle));
      chk("region", 64'(shift_region_flag), 64'(region));
      repeat (lat) @(negedge clk);
      ready_cordic = 1'b1;
      data_output  = d;
      {overflow_flag, underflow_flag} = f;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ack_cordic && n < BUDGET);
      chk("ack_lat", 64'(n), 1);
      repeat (hold) begin
        chk("valid_early", 64'(rsp_valid), 0);
        @(negedge clk);
      end
      chk("op_held", 64'(operation), 64'(exp_op));
      chk("din_held", 64'(data_in), 64'(angle));
      ready_cordic = 1'b0;
      data_output  = $urandom;
      {overflow_flag, underflow_flag} = 2'($urandom);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!rsp_valid && n < BUDGET);
      chk("valid_lat", 64'(n), (hold == 0) ? 2 : 1);
      for (int s = 0; s < stall; s++) begin
        rsp_ready  = 1'b0;
        cmd_valid  = 1'b1;
        cmd_mode   = 2'($urandom);
        chk("stall_data", 64'(rsp_data), 64'(d));
        chk("stall_valid", 64'(rsp_valid), 1);
        chk("stall_cmd_ready", 64'(cmd_ready), 0);
        chk("stall_beg", 64'(beg_fsm_cordic), 0);
        @(negedge clk);
      end
      cmd_valid = 1'b0;
      chk("rsp_valid", 64'(rsp_valid), 1);
      chk("rsp_data", 64'(rsp_data), 64'(d));
      chk("rsp_op", 64'(rsp_op), 64'(exp_op));
      chk("rsp_ovf", 64'(rsp_ovf), 64'(f[1]));
      chk("rsp_unf", 64'(rsp_unf), 64'(f[0]));
      chk("rsp_last", 64'(rsp_last), 64'(exp_last));
      chk("rsp_timeout", 64'(rsp_timeout), 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", 64'(rsp_valid), 0);
      if (exp_last) chk("cmd_ready_back", 64'(cmd_ready), 1);
      else chk("beg_second", 64'(beg_fsm_cordic), 1);
    end
    chk("beg_count", 64'(n_beg - beg0), 64'(npass));
    chk("ack_count", 64'(n_ack - ack0), 64'(npass));
  endtask

  initial begin
    int n, b0;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_angle = '0;
    cmd_region = '0;
    cmd_mode = '0;
    rsp_ready = 1'b0;
    ready_cordic = 1'b0;
    data_output = '0;
    overflow_flag = 1'b0;
    underflow_flag = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst = 1'b1;
    @(negedge clk);

    run_cmd(32'h3F000000, 2'b00, 2'b00, 32'h3F60A8B6, 32'h0, 2'b00, 2'b00, LAT_MAX, 0, 0);
    run_cmd(32'h3F000000, 2'b00, 2'b10, 32'h3F60A8B6, 32'h3EF57744, 2'b00, 2'b00, 5, 0, 0);
    run_cmd($urandom, 2'b01, 2'b01, $urandom, 32'h0, 2'b01, 2'b00, 3, 1, 10);
    run_cmd($urandom, 2'b11, 2'b11, $urandom, $urandom, 2'b10, 2'b01, 4, 3, 1);

    // Reset while the datapath is still working on a request.
    cmd_valid = 1'b1;
    cmd_angle = 32'h40490FDB;
    cmd_region = 2'b10;
    cmd_mode = 2'b10;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rw_beg", 64'(beg_fsm_cordic), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("rw_a");
    @(negedge clk);
    chk("rw_cmd_ready", 64'(cmd_ready), 1);
    rst = 1'b1;
    b0 = n_beg;
    repeat (8) @(negedge clk);
    chk("rw_no_rsp", 64'(rsp_valid), 0);
    chk("rw_no_beg", 64'(n_beg - b0), 0);
    chk("rw_idle", 64'(cmd_ready), 1);

`ifdef CORDIC_HOST_TIMEOUT_EN
    // Datapath never answers a "both" command: one aborted pass, second pass abandoned.
    b0 = n_beg;
    cmd_valid = 1'b1;
    cmd_angle = 32'h3F000000;
    cmd_mode = 2'b10;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("tmo_beg", 64'(beg_fsm_cordic), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_cordic && n < BUDGET);
    chk("tmo_ack_lat", 64'(n), 64'(TMO + 1));
    @(negedge clk);
    chk("tmo_valid", 64'(rsp_valid), 1);
    chk("tmo_data", 64'(rsp_data), 0);
    chk("tmo_flag", 64'(rsp_timeout), 1);
    chk("tmo_last", 64'(rsp_last), 1);
    chk("tmo_ovf_unf", 64'({rsp_ovf, rsp_unf}), 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("tmo_idle", 64'(cmd_ready), 1);
    repeat (3) @(negedge clk);
    chk("tmo_beg_count", 64'(n_beg - b0), 1);
`endif

    for (int i = 0; i < 20; i++) begin
      run_cmd($urandom, 2'($urandom), 2'($urandom), $urandom, $urandom,
              2'($urandom), 2'($urandom), $urandom_range(LAT_MAX, 1),
              $urandom_range(3, 0), $urandom_range(4, 0));
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cordic_sincos_host.md
# cordic_sincos_host

Host-side requester for the sine/cosine CORDIC datapath. It drives the datapath's start/acknowledge handshake: it takes angle commands from a valid/ready command port, starts the datapath, waits for its result, acknowledges it, and returns the result on a valid/ready response port. One command can request cosine, sine, or both. In "both" mode the block runs two back-to-back datapath transactions (cosine first).

## Interface
Parameters:
- W, 32: floating-point word width (32 single, 64 double)
- TIMEOUT_CYCLES, 1023: watchdog limit in cycles; used only with CORDIC_HOST_TIMEOUT_EN
- TO_W, 10: watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
- cmd_angle  in  W  angle in radians, IEEE-754
- cmd_region  in  2  range region code, forwarded to shift_region_flag
- cmd_mode  in  2  00 cos, 01 sin, 10 both, 11 treated as 10
- rsp_valid  out  1  result present
- rsp_ready  in  1  result consumed
- rsp_data  out  W  result word
- rsp_op  out  1  1 = sine, 0 = cosine
- rsp_ovf / rsp_unf  out  1 each  captured overflow / underflow flags
- rsp_last  out  1  final response of the command
- rsp_timeout  out  1  watchdog abort; constant 0 without the macro
- beg_fsm_cordic  out  1  one-cycle start pulse
- ack_cordic  out  1  one-cycle result acknowledge
- operation  out  1  1 = sine, 0 = cosine
- data_in  out  W  angle to the datapath
- shift_region_flag  out  2  region to the datapath
- ready_cordic  in  1  datapath result valid; held high until ack
- data_output  in  W  datapath result
- overflow_flag / underflow_flag  in  1 each  datapath flags

## Operation
- States: IDLE, START, WAIT, ACK, RELEASE, OUT.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch angle, region and mode, set pass = 0, go to START.
- START:
  - beg_fsm_cordic = 1 for exactly one cycle.
  - operation = 1 if mode is sin, or if mode is both and pass = 1; otherwise 0.
  - Go to WAIT.
- WAIT: when ready_cordic = 1, capture data_output, overflow_flag and underflow_flag into the response registers, then go to ACK.
- ACK: ack_cordic = 1 for one cycle, then go to RELEASE.
- RELEASE: wait until ready_cordic = 0, then go to OUT.
- OUT:
  - rsp_valid = 1.
  - rsp_last = 1 unless mode is both and pass = 0.
  - On rsp_ready: if rsp_last, go to IDLE; otherwise set pass = 1 and go to START.
- data_in, shift_region_flag and operation stay stable from START until the transaction leaves RELEASE.
- Response fields stay stable while rsp_valid = 1 and rsp_ready = 0.
- cmd_ready is 0 in every state except IDLE; commands presented while busy are not accepted.

## Timing
- Reset values: every output is 0 except cmd_ready. cmd_ready is the IDLE decode, so it reads 1 while rst is low. No command is accepted while rst is low.
- Reset in mid-operation returns the block to IDLE immediately and discards the pending response. The datapath shares the same system reset.
- Command accepted at cycle T: beg_fsm_cordic is high at T+1, WAIT starts at T+2.
- ready_cordic first sampled high in WAIT at cycle R: ack_cordic is high at R+1 and rsp_valid at R+3 at the earliest (ready_cordic low at R+2).
- With rsp_ready held high, OUT lasts one cycle. In "both" mode the second beg_fsm_cordic is then one cycle after the first OUT cycle.
- cmd_valid and rsp_ready are independent. A command is accepted only from IDLE.

## Configuration
- Macro: CORDIC_HOST_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES with ready_cordic still low, the block:
    - sets rsp_data = 0, rsp_ovf = rsp_unf = 0;
    - sets rsp_timeout = 1 and rsp_last = 1 (any second "both" pass is abandoned);
    - pulses ack_cordic for one cycle, then goes straight to OUT, skipping RELEASE.
- Not defined: WAIT has no time limit, rsp_timeout is constant 0, and the counter is not built.

## Structure
- Shared package cordic_host_pkg holds:
  - the state enum;
  - mode codes MODE_COS, MODE_SIN, MODE_BOTH;
  - OP_SIN = 1, OP_COS = 0.
- Sub-module cordic_host_watchdog: the TO_W-bit counter with clear, enable and expired outputs. It is instantiated only under CORDIC_HOST_TIMEOUT_EN.

## Test plan
- Cosine: cmd_angle 0x3F000000, mode 00, region 00; datapath model raises ready_cordic 20 cycles after beg with 0x3F60A8B6. Expect one response: rsp_data 0x3F60A8B6, rsp_op 0, rsp_last 1, and exactly one beg and one ack pulse.
- Both mode: angle 0x3F000000, mode 10; model returns 0x3F60A8B6, then 0x3EF57744. Expect two responses (op 0 with last 0, then op 1 with last 1) and operation = 1 during the second transaction.
- Backpressure: rsp_ready held 0 for 10 cycles in OUT. rsp_data stays stable, no new beg is issued, and cmd_ready stays 0 throughout.
- Flags and release: model asserts overflow_flag and holds ready_cordic high 3 cycles after ack. Expect rsp_ovf = 1 and rsp_valid only after ready_cordic falls.
- Reset in WAIT: assert rst low for 2 cycles. All outputs return to their reset values, cmd_ready reads 1, and no response is produced.
- Timeout (macro defined, TIMEOUT_CYCLES 15): model never raises ready. Expect an ack pulse 15 cycles into WAIT, then rsp_valid with rsp_data 0, rsp_timeout 1, rsp_last 1.
